// File: rtl/log2_seq_ctrl.sv
// Sequential log2/log10 of one signed fixed-point sample: normalize, ROM fetch, 2 Horner MACs, add exponent, optional log10 scale.
// Latency: out_valid k+5 cycles after accept (k = normalization shifts), k+6 for log10; non-positive input reports err in the cycle after accept.
// Backpressure: in_ready only in IDLE; Result/err held in DONE until out_ready; one sample in flight at a time.
module log2_seq_ctrl #(
    parameter int xWI       = 2,
    parameter int xWF       = 23,
    parameter int cWI       = 2,
    parameter int cWF       = 26,
    parameter int aWI       = 2,
    parameter int aWF       = 28,
    parameter int yWI       = 6,
    parameter int yWF       = 19,
    parameter int noSegBits = 12
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [xWI+xWF-1:0]         Number,
    input  logic                       base10,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       rom_en,
    output logic [noSegBits-1:0]       rom_addr,
    input  logic [3*(cWI+cWF)-1:0]     rom_data,
    output logic [yWI+yWF-1:0]         Result,
    output logic                       err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int xWL = xWI + xWF;
    localparam int cWL = cWI + cWF;
    localparam int aWL = aWI + aWF;
    localparam int yWL = yWI + yWF;
    localparam int XOW = xWF - noSegBits;     // fractional offset inside a segment
    localparam int EW  = 8;                   // exponent width, covers 0 .. -(xWL-2)
    localparam int MW  = xWF + aWL;           // Horner product width before the 2^-xWF drop
    localparam int SW  = cWF + yWL;           // log10 scale product width before the 2^-cWF drop
    localparam int K_SCALE = int'(0.30103 * (2.0 ** cWF));
    localparam logic signed [31:0] Y_MAX = (32'sd1 <<< (yWL - 1)) - 32'sd1;
    localparam logic signed [31:0] Y_MIN = -(32'sd1 <<< (yWL - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_NORM, S_FETCH, S_MAC1, S_MAC2, S_ADD, S_SCALE, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [xWL-2:0]         mant_q, mant_d;
    logic signed [EW-1:0]   e_q, e_d;
    logic                   b10_q, b10_d;
    logic [noSegBits-1:0]   addr_q, addr_d;
    logic [XOW-1:0]         xo_q, xo_d;
    logic signed [aWL-1:0]  c0_q, c0_d;
    logic signed [aWL-1:0]  acc_q, acc_d;
    logic [yWL-1:0]         y_q, y_d;
    logic                   err_q, err_d;

    logic signed [cWL-1:0]  c2_s, c1_s, c0_s;
    logic signed [aWL-1:0]  c2_a, c1_a, c0_a;
    logic signed [aWL-1:0]  mul_b, mul_t;
    logic signed [MW-1:0]   mul_p;
    logic signed [31:0]     y_sum, y_sat;
    logic signed [SW-1:0]   sc_p;
    logic                   unused_bits;

    // Datapath: coefficient alignment, the shared Horner multiplier, exponent add with saturation, log10 scaling.
    always_comb begin
        c2_s  = rom_data[3*cWL-1:2*cWL];
        c1_s  = rom_data[2*cWL-1:cWL];
        c0_s  = rom_data[cWL-1:0];
        c2_a  = aWL'(c2_s) <<< (aWF - cWF);
        c1_a  = aWL'(c1_s) <<< (aWF - cWF);
        c0_a  = aWL'(c0_s) <<< (aWF - cWF);
        // MAC1 multiplies by c2, MAC2 by the running accumulator
        mul_b = (state_q == S_MAC1) ? c2_a : acc_q;
        mul_p = MW'($signed({1'b0, xo_q})) * MW'(mul_b);
        mul_t = mul_p[xWF +: aWL];
        y_sum = (32'(e_q) <<< yWF) + 32'(acc_q >>> (aWF - yWF));
        if (y_sum > Y_MAX) begin
            y_sat = Y_MAX;
        end else if (y_sum < Y_MIN) begin
            y_sat = Y_MIN;
        end else begin
            y_sat = y_sum;
        end
        sc_p  = SW'($signed(y_q)) * SW'(K_SCALE);
    end

    // Low product bits are dropped by the floor truncation; high bits of y_sat are covered by saturation.
    assign unused_bits = ^{mul_p[xWF-1:0], sc_p[cWF-1:0], y_sat[31:yWL]};

    // Next-state and register-update logic for the controller.
    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        e_d     = e_q;
        b10_d   = b10_q;
        addr_d  = addr_q;
        xo_d    = xo_q;
        c0_d    = c0_q;
        acc_d   = acc_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (Number[xWL-1] || (Number == '0)) begin
                        err_d   = 1'b1;
                        y_d     = {1'b1, {(yWL-1){1'b0}}};
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        mant_d  = Number[xWL-2:0];
                        e_d     = EW'(xWI - 2);
                        b10_d   = base10;
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (!mant_q[xWL-2]) begin
                    mant_d = {mant_q[xWL-3:0], 1'b0};
                    e_d    = e_q - EW'(1);
                end else begin
                    addr_d  = mant_q[xWF-1 -: noSegBits];
                    xo_d    = mant_q[XOW-1:0];
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_MAC1;
            S_MAC1: begin
                c0_d    = c0_a;
                acc_d   = c1_a + mul_t;
                state_d = S_MAC2;
            end
            S_MAC2: begin
                acc_d   = c0_q + mul_t;
                state_d = S_ADD;
            end
            S_ADD: begin
                y_d     = y_sat[yWL-1:0];
                state_d = b10_q ? S_SCALE : S_DONE;
            end
            S_SCALE: begin
                y_d     = sc_p[cWF +: yWL];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            mant_q  <= '0;
            e_q     <= '0;
            b10_q   <= 1'b0;
            addr_q  <= '0;
            xo_q    <= '0;
            c0_q    <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            e_q     <= e_d;
            b10_q   <= b10_d;
            addr_q  <= addr_d;
            xo_q    <= xo_d;
            c0_q    <= c0_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    // in_ready is gated by Rst so it reads 0 while reset is held even though the state is IDLE.
    assign in_ready  = Rst && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign rom_en    = (state_q == S_FETCH);
    assign rom_addr  = addr_q;
    assign Result    = y_q;
    assign err       = err_q;

endmodule

// File: tb/tb_log2_seq_ctrl.sv
// Bench for log2_seq_ctrl: directed corner samples plus model-checked samples through a scoreboard queue.
// Outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
// Exercises output backpressure, abort by reset, and back-to-back samples.
module tb_log2_seq_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [24:0] Number = '0;
    logic        base10 = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [83:0] rom_data = '0;
    logic [24:0] Result;
    logic        err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    int total = 0;
    int bad = 0;
    int rom_seen = 0;
    int rom_base = 0;

    typedef struct {
        logic [24:0] res;
        logic        er;
        int          lat;
        int          tol;
        int          pulses;
        logic [11:0] addr;
        logic        chk_addr;
    } exp_t;

    exp_t sb[$];

    log2_seq_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Number(Number), .base10(base10),
        .in_valid(in_valid), .in_ready(in_ready), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .Result(Result),
        .err(err), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Coefficient table: c0 of segment 0 is zero, everything else arbitrary but small.
    function automatic logic [83:0] rom_word(input logic [11:0] a);
        int ai;
        logic [27:0] c0, c1, c2;
        ai = int'(a);
        c0 = 28'(ai * 4099);
        c1 = 28'(ai * 3001 - 8388608);
        c2 = 28'(4194304 - ai * 2011);
        return {c2, c1, c0};
    endfunction

    // Synchronous ROM: data valid the cycle after rom_en
    always @(posedge Clk) if (rom_en) rom_data <= rom_word(rom_addr);

    always @(negedge Clk) if (rom_en) rom_seen++;

    function automatic longint wrap30(input longint x);
        logic signed [29:0] b;
        b = x[29:0];
        return longint'(b);
    endfunction

    function automatic exp_t mk(input logic [24:0] r, input logic e, input int lat,
                                input int tol, input int pulses, input logic [11:0] a, input logic chk);
        exp_t ex;
        ex.res = r; ex.er = e; ex.lat = lat; ex.tol = tol;
        ex.pulses = pulses; ex.addr = a; ex.chk_addr = chk;
        return ex;
    endfunction

    // Reference model of the arithmetic for positive samples.
    function automatic exp_t model_exp(input logic [24:0] num, input logic b10);
        exp_t ex;
        logic [24:0] m;
        logic [11:0] a;
        logic [83:0] w;
        logic signed [27:0] t28;
        longint xo, c2, c1, c0, acc, y;
        int k;
        m = num; k = 0;
        while (!m[23] && k < 30) begin
            m = m << 1;
            k++;
        end
        a  = m[22:11];
        xo = longint'(m[10:0]);
        w  = rom_word(a);
        t28 = w[83:56]; c2 = longint'(t28) * 4;
        t28 = w[55:28]; c1 = longint'(t28) * 4;
        t28 = w[27:0];  c0 = longint'(t28) * 4;
        acc = wrap30(c1 + wrap30((xo * c2) >>> 23));
        acc = wrap30(c0 + wrap30((xo * acc) >>> 23));
        y = longint'(-k) * 524288 + (acc >>> 9);
        if (y > 16777215) y = 16777215;
        if (y < -16777216) y = -16777216;
        // K = round(0.30103 * 2^26) = 20201781
        if (b10) y = (y * 20201781) >>> 26;
        ex = mk(y[24:0], 1'b0, k + 5 + (b10 ? 1 : 0), 0, 1, a, 1'b1);
        return ex;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [24:0] num, input logic b10, input exp_t ex);
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL in_ready_idle got=%b want=1", in_ready);
            bad++;
        end
        Number   = num;
        base10   = b10;
        in_valid = 1'b1;
        rom_base = rom_seen;
        tick;
        in_valid = 1'b0;
        sb.push_back(ex);
    endtask

    task automatic collect(input string name, input int hold);
        int n;
        int d;
        exp_t ex;
        logic [24:0] keep;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s timeout out_valid=%b after %0d cycles", name, out_valid, n);
            bad++;
            if (sb.size() > 0) ex = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            $display("FAIL %s unexpected output result=%h", name, Result);
            bad++;
            return;
        end
        ex = sb.pop_front();
        if (n !== ex.lat) begin
            $display("FAIL %s latency got=%0d want=%0d", name, n, ex.lat);
            bad++;
        end
        total++;
        if (err !== ex.er) begin
            $display("FAIL %s err got=%b want=%b", name, err, ex.er);
            bad++;
        end
        total++;
        d = $signed(Result) - $signed(ex.res);
        if (d > ex.tol || d < -ex.tol) begin
            $display("FAIL %s result got=%h want=%h tol=%0d", name, Result, ex.res, ex.tol);
            bad++;
        end
        total++;
        if ((rom_seen - rom_base) !== ex.pulses) begin
            $display("FAIL %s rom_en_pulses got=%0d want=%0d", name, rom_seen - rom_base, ex.pulses);
            bad++;
        end
        if (ex.chk_addr) begin
            total++;
            if (rom_addr !== ex.addr) begin
                $display("FAIL %s rom_addr got=%h want=%h", name, rom_addr, ex.addr);
                bad++;
            end
        end
        if (hold > 0) begin
            out_ready = 1'b0;
            keep = Result;
            for (int i = 0; i < hold; i++) begin
                tick;
                total++;
                if ({out_valid, in_ready, busy, Result} !== {1'b1, 1'b0, 1'b1, keep}) begin
                    $display("FAIL %s hold ov/ir/busy/result got=%b%b%b/%h want=110/%h",
                             name, out_valid, in_ready, busy, Result, keep);
                    bad++;
                end
            end
            out_ready = 1'b1;
        end
        tick;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s release out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
            bad++;
        end
    endtask

    task automatic test_reset;
        total++;
        if ({Result, err, out_valid, rom_en, rom_addr, busy, in_ready} !== 42'h0) begin
            $display("FAIL reset_outputs got=%h want=0",
                     {Result, err, out_valid, rom_en, rom_addr, busy, in_ready});
            bad++;
        end
        tick;
        Rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release in_ready=%b busy=%b want 1/0", in_ready, busy);
            bad++;
        end
        tick;
    endtask

    task automatic test_powers;
        send(25'h0800000, 1'b0, mk(25'h0000000, 1'b0, 5, 0, 1, 12'h000, 1'b1));
        collect("one", 0);
        send(25'h0400000, 1'b0, mk(25'h1F80000, 1'b0, 6, 0, 1, 12'h000, 1'b1));
        collect("half", 0);
        send(25'h0000001, 1'b0, mk(25'h1480000, 1'b0, 28, 0, 1, 12'h000, 1'b1));
        collect("tiny", 0);
    endtask

    task automatic test_nonpos;
        send(25'h0000000, 1'b0, mk(25'h1000000, 1'b1, 0, 0, 0, 12'h000, 1'b0));
        collect("zero", 0);
        send(25'h1FFFFFF, 1'b1, mk(25'h1000000, 1'b1, 0, 0, 0, 12'h000, 1'b0));
        collect("neg_lsb", 0);
    endtask

    task automatic test_log10_hold;
        logic [24:0] want;
        want = 25'(-157826);
        send(25'h0400000, 1'b1, mk(want, 1'b0, 7, 1, 1, 12'h000, 1'b1));
        collect("log10_half", 10);
    endtask

    task automatic test_mac;
        logic [24:0] nums [8];
        logic        b10s [8];
        nums = '{25'h0C00000, 25'h0C00005, 25'h0ABCDEF, 25'h0012345,
                 25'h0FFFFFF, 25'h0000FFF, 25'h07FFFFF, 25'h09A37C1};
        b10s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            send(nums[i], b10s[i], model_exp(nums[i], b10s[i]));
            collect("mac", 0);
        end
    endtask

    task automatic test_reset_abort;
        send(25'h0000001, 1'b0, mk(25'h1480000, 1'b0, 28, 0, 1, 12'h000, 1'b1));
        repeat (5) tick;
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL abort_busy got=%b want=1", busy);
            bad++;
        end
        Rst = 1'b0;
        #1;
        total++;
        if ({Result, err, out_valid, rom_en, rom_addr, busy, in_ready} !== 42'h0) begin
            $display("FAIL abort_outputs got=%h want=0",
                     {Result, err, out_valid, rom_en, rom_addr, busy, in_ready});
            bad++;
        end
        sb.delete();
        tick;
        Rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL abort_release in_ready=%b want=1", in_ready);
            bad++;
        end
        send(25'h0800000, 1'b0, mk(25'h0000000, 1'b0, 5, 0, 1, 12'h000, 1'b1));
        collect("after_abort", 0);
    endtask

    task automatic test_back_to_back;
        logic [24:0] num;
        logic        b10;
        for (int i = 0; i < 6; i++) begin
            num = 25'($urandom_range(1, 24'hFFFFFF));
            b10 = 1'($urandom_range(0, 1));
            send(num, b10, model_exp(num, b10));
            collect("b2b", 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        test_reset;
        test_powers;
        test_nonpos;
        test_log10_hold;
        test_mac;
        test_reset_abort;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
